// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM state
// encoding, Funct3 access codes and offset helpers used by both the
// lane-steering logic and the load formatter.
package lsu_pkg;

   // Transaction FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,   // accept a new access
      REQ  = 2'd1,   // request presented, waiting for ready
      RESP = 2'd2,   // load accepted, waiting for response data
      DONE = 2'd3    // one cycle presenting formatted load data
   } lsu_state_e;

   // Funct3 access size / sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Access size lives in Funct3[1:0]
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // Force the byte offset to the natural alignment of the access size.
   function automatic logic [1:0] align_off(input logic [1:0] off,
                                            input logic [1:0] size);
      logic [1:0] res;
      case (size)
         SZ_H:    res = {off[1], 1'b0};
         SZ_W:    res = 2'b00;
         default: res = off;
      endcase
      return res;
   endfunction

   // A half needs addr[0]=0, a word needs addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] off,
                                          input logic [1:0] size);
      logic res;
      case (size)
         SZ_H:    res = off[0];
         SZ_W:    res = |off;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: picks the byte or half at the given offset out of
// the captured memory word and sign- or zero-extends it according to
// Funct3. Purely combinational.
module load_formatter
   import lsu_pkg::*;
#(
   parameter int word_width = 32
) (
   input  logic [word_width-1:0] word_i,
   input  logic [1:0]            off_i,
   input  logic [2:0]            funct3_i,
   output logic [word_width-1:0] result_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane extraction followed by extension selected by Funct3
   always_comb begin
      byte_sel = word_i[7:0];
      half_sel = word_i[15:0];
      result_o = word_i;

      case (off_i)
         2'd0:    byte_sel = word_i[7:0];
         2'd1:    byte_sel = word_i[15:8];
         2'd2:    byte_sel = word_i[23:16];
         default: byte_sel = word_i[31:24];
      endcase

      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

      case (funct3_i)
         F3_B:    result_o = {{(word_width-8){byte_sel[7]}}, byte_sel};
         F3_BU:   result_o = {{(word_width-8){1'b0}}, byte_sel};
         F3_H:    result_o = {{(word_width-16){half_sel[15]}}, half_sel};
         F3_HU:   result_o = {{(word_width-16){1'b0}}, half_sel};
         default: result_o = word_i;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// Memory (M) stage load/store unit. Runs one data-memory transaction per
// access over a valid/ready request bus and a valid-qualified response,
// steers store data into byte lanes, formats load data and stalls the
// pipeline until the access completes.
//
// Build option: define LSU_MISALIGN_TRAP_EN to flag misaligned halves and
// words on MisalignM and suppress their request; without it the offset is
// silently forced aligned and MisalignM is tied low.
module memory_stage
   import lsu_pkg::*;
#(
   parameter int word_width = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Funct3M,
   input  logic [word_width-1:0] ALUResultM,
   input  logic [word_width-1:0] WriteDataM,
   output logic                  dmem_req_valid,
   input  logic                  dmem_req_ready,
   output logic                  dmem_we,
   output logic [word_width-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [word_width-1:0] dmem_wdata,
   input  logic                  dmem_rsp_valid,
   input  logic [word_width-1:0] dmem_rdata,
   output logic [word_width-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  MisalignM
);

   lsu_state_e            state_q, state_d;
   logic [word_width-1:0] rdata_q, rdata_d;

   logic                  access;
   logic [1:0]            off_raw;
   logic [1:0]            off_al;
   logic                  mis;
   logic                  valid_c;
   logic                  stall_c;
   logic                  misalign_c;
   logic [3:0]            be_c;
   logic [word_width-1:0] wdata_c;
   logic [word_width-1:0] fmt_data;

   assign access  = MemReadM | MemWriteM;
   assign off_raw = ALUResultM[1:0];
   assign off_al  = align_off(off_raw, Funct3M[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = access & is_misaligned(off_raw, Funct3M[1:0]);
`else
   assign mis = 1'b0;
`endif

   // Store lane steering: byte enables and replicated store data
   always_comb begin
      be_c    = 4'b0000;
      wdata_c = WriteDataM;
      if (MemReadM) begin
         be_c = 4'b1111;
      end else if (MemWriteM) begin
         case (Funct3M[1:0])
            SZ_B: begin
               be_c    = 4'b0001 << off_al;
               wdata_c = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
               be_c    = 4'b0011 << off_al;
               wdata_c = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_c    = 4'b1111;
               wdata_c = WriteDataM;
            end
         endcase
      end
   end

   // Transaction FSM: next state, request valid, stall and load capture
   always_comb begin
      state_d    = state_q;
      rdata_d    = rdata_q;
      valid_c    = 1'b0;
      stall_c    = 1'b0;
      misalign_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (access) begin
               if (mis) begin
                  // Misaligned access: flag it and let it leave without a request
                  misalign_c = 1'b1;
               end else begin
                  valid_c = 1'b1;
                  if (MemWriteM) begin
                     // A store accepted immediately finishes in this cycle
                     stall_c = ~dmem_req_ready;
                     if (!dmem_req_ready) begin
                        state_d = REQ;
                     end
                  end else begin
                     stall_c = 1'b1;
                     state_d = dmem_req_ready ? RESP : REQ;
                  end
               end
            end
         end

         REQ: begin
            valid_c = 1'b1;
            if (dmem_req_ready) begin
               if (MemReadM) begin
                  stall_c = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               stall_c = 1'b1;
            end
         end

         RESP: begin
            stall_c = 1'b1;
            if (dmem_rsp_valid) begin
               rdata_d = dmem_rdata;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured load word; reset abandons any access in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   load_formatter #(
      .word_width (word_width)
   ) u_load_formatter (
      .word_i   (rdata_q),
      .off_i    (off_al),
      .funct3_i (Funct3M),
      .result_o (fmt_data)
   );

   // Outputs are forced quiet while reset is asserted
   assign dmem_req_valid = reset & valid_c;
   assign dmem_we        = reset & MemWriteM & ~mis;
   assign dmem_addr      = {ALUResultM[word_width-1:2], 2'b00};
   assign dmem_be        = (reset && !mis) ? be_c : 4'b0000;
   assign dmem_wdata     = wdata_c;
   assign ReadDataM      = (reset && !mis) ? fmt_data : '0;
   assign StallM         = reset & stall_c;
   assign MisalignM      = reset & misalign_c;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus randomized accesses
// compared against an arithmetic model of lane steering, load formatting
// and stall latency. Honours LSU_MISALIGN_TRAP_EN if defined for the build.
`timescale 1ns/1ps
module tb_memory_stage;

   localparam logic [2:0] T_B  = 3'b000;
   localparam logic [2:0] T_H  = 3'b001;
   localparam logic [2:0] T_W  = 3'b010;
   localparam logic [2:0] T_BU = 3'b100;
   localparam logic [2:0] T_HU = 3'b101;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM;
   logic        dmem_req_valid, dmem_req_ready, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, ReadDataM;
   logic [3:0]  dmem_be;
   logic        dmem_rsp_valid, StallM, MisalignM;

   int n_checks = 0;
   int n_pass   = 0;

   // Observations gathered by the transaction driver
   int          obs_stalls, obs_valids;
   logic [31:0] obs_addr, obs_wdata, obs_rdm;
   logic [3:0]  obs_be;
   logic        obs_we, obs_stable, obs_mis, obs_timeout, obs_done_valid;

   always #5 clk = ~clk;

   memory_stage #(.word_width(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .MemReadM       (MemReadM),
      .MemWriteM      (MemWriteM),
      .Funct3M        (Funct3M),
      .ALUResultM     (ALUResultM),
      .WriteDataM     (WriteDataM),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rdata     (dmem_rdata),
      .ReadDataM      (ReadDataM),
      .StallM         (StallM),
      .MisalignM      (MisalignM)
   );

   // ---------------- reference model ----------------
   function automatic logic [1:0] m_off(input logic [2:0] f3, input logic [31:0] addr);
      int sz = int'(f3 % 4);
      if (sz == 1) return addr[1:0] & 2'b10;
      if (sz == 2) return 2'b00;
      return addr[1:0];
   endfunction

   function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
      int sz = int'(f3 % 4);
      return (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] m_be(input logic ld, input logic [2:0] f3, input logic [31:0] addr);
      int sz = int'(f3 % 4);
      int o  = int'(m_off(f3, addr));
      if (ld) return 4'hF;
      if (sz == 0) return 4'(1 << o);
      if (sz == 1) return 4'(3 << o);
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int sz = int'(f3 % 4);
      if (sz == 0) return {4{wd[7:0]}};
      if (sz == 1) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> (8 * int'(m_off(f3, addr)));
      case (f3)
         T_B:     return {{24{sh[7]}}, sh[7:0]};
         T_BU:    return {24'h0, sh[7:0]};
         T_H:     return {{16{sh[15]}}, sh[15:0]};
         T_HU:    return {16'h0, sh[15:0]};
         default: return rd;
      endcase
   endfunction

   // ---------------- driver ----------------
   // Called just after a rising edge. Presents one access and plays the
   // memory: ready after rdy_dly waiting cycles, response rsp_lat cycles
   // after acceptance. Ends after the first non-stalled cycle.
   task automatic run_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int rdy_dly, input int rsp_lat,
                             input logic [31:0] rd, input logic noise);
      int   waited, k;
      logic acc, acc_now, v_s, first;
      MemReadM = ld; MemWriteM = ~ld; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
      dmem_req_ready = (rdy_dly == 0); dmem_rsp_valid = 1'b0; dmem_rdata = $urandom;
      obs_stalls = 0; obs_valids = 0; obs_stable = 1'b1; obs_timeout = 1'b1;
      obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0; obs_rdm = '0;
      obs_mis = 1'b0; obs_done_valid = 1'b0;
      waited = 0; k = 0; acc = 1'b0; first = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         if (first) obs_mis = MisalignM;
         first = 1'b0;
         v_s = dmem_req_valid;
         if (dmem_req_valid) begin
            obs_valids++;
            if (obs_valids == 1) begin
               obs_addr = dmem_addr; obs_be = dmem_be; obs_wdata = dmem_wdata; obs_we = dmem_we;
            end else if (dmem_addr !== obs_addr || dmem_be !== obs_be ||
                         dmem_wdata !== obs_wdata || dmem_we !== obs_we) begin
               obs_stable = 1'b0;
            end
         end
         acc_now = dmem_req_valid & dmem_req_ready;
         if (StallM === 1'b1) obs_stalls++;
         else begin
            obs_rdm = ReadDataM; obs_done_valid = dmem_req_valid; obs_timeout = 1'b0;
         end
         @(posedge clk); #1;
         if (!obs_timeout) break;
         if (acc_now) begin acc = 1'b1; k = 1; end
         else if (acc) k++;
         if (acc) begin
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = (k == rsp_lat);
            dmem_rdata     = (k == rsp_lat) ? rd : $urandom;
         end else begin
            if (v_s && !dmem_req_ready) waited++;
            dmem_req_ready = (waited >= rdy_dly);
            if (noise) begin
               dmem_rsp_valid = 1'($urandom_range(0, 1));
               dmem_rdata     = $urandom;
            end
         end
      end
      MemReadM = 1'b0; MemWriteM = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      reset = 1'b0;
      MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = T_W; ALUResultM = 32'h100; WriteDataM = 32'h0;
      dmem_req_ready = 1'b1; dmem_rsp_valid = 1'b0; dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (dmem_req_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dmem_req_valid); else n_pass++;
      n_checks++; if (StallM !== 1'b0) $display("FAIL rst_stall: got %b want 0", StallM); else n_pass++;
      n_checks++; if (MisalignM !== 1'b0) $display("FAIL rst_misalign: got %b want 0", MisalignM); else n_pass++;
      n_checks++; if (ReadDataM !== 32'h0) $display("FAIL rst_rdata: got %h want 0", ReadDataM); else n_pass++;
      n_checks++; if (dmem_be !== 4'h0) $display("FAIL rst_be: got %h want 0", dmem_be); else n_pass++;
      MemReadM = 1'b0; MemWriteM = 1'b1;
      #1;
      n_checks++; if (dmem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", dmem_we); else n_pass++;
      @(posedge clk); #1;
      MemWriteM = 1'b0; dmem_req_ready = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_sw;
      run_access(1'b0, T_W, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, 1'b0);
      n_checks++; if (obs_timeout !== 1'b0) $display("FAIL sw_timeout: got %b want 0", obs_timeout); else n_pass++;
      n_checks++; if (obs_valids !== 1) $display("FAIL sw_valid_cycles: got %0d want 1", obs_valids); else n_pass++;
      n_checks++; if (obs_stalls !== 0) $display("FAIL sw_stalls: got %0d want 0", obs_stalls); else n_pass++;
      n_checks++; if (obs_we !== 1'b1) $display("FAIL sw_we: got %b want 1", obs_we); else n_pass++;
      n_checks++; if (obs_be !== 4'hF) $display("FAIL sw_be: got %h want f", obs_be); else n_pass++;
      n_checks++; if (obs_addr !== 32'h100) $display("FAIL sw_addr: got %h want 00000100", obs_addr); else n_pass++;
      n_checks++; if (obs_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h want deadbeef", obs_wdata); else n_pass++;
   endtask

   task automatic test_sb_wait;
      run_access(1'b0, T_B, 32'h103, 32'h000000A5, 2, 1, 32'h0, 1'b0);
      n_checks++; if (obs_valids !== 3) $display("FAIL sb_valid_cycles: got %0d want 3", obs_valids); else n_pass++;
      n_checks++; if (obs_stalls !== 2) $display("FAIL sb_stalls: got %0d want 2", obs_stalls); else n_pass++;
      n_checks++; if (obs_be !== 4'b1000) $display("FAIL sb_be: got %b want 1000", obs_be); else n_pass++;
      n_checks++; if (obs_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h want a5a5a5a5", obs_wdata); else n_pass++;
      n_checks++; if (obs_stable !== 1'b1) $display("FAIL sb_req_stable: got %b want 1", obs_stable); else n_pass++;
   endtask

   task automatic test_lb;
      run_access(1'b1, T_B, 32'h101, 32'h0, 0, 1, 32'h000080FF, 1'b0);
      n_checks++; if (obs_stalls !== 2) $display("FAIL lb_stalls: got %0d want 2", obs_stalls); else n_pass++;
      n_checks++; if (obs_rdm !== 32'hFFFFFF80) $display("FAIL lb_data: got %h want ffffff80", obs_rdm); else n_pass++;
      n_checks++; if (obs_done_valid !== 1'b0) $display("FAIL lb_done_valid: got %b want 0", obs_done_valid); else n_pass++;
      n_checks++; if (obs_be !== 4'hF || obs_we !== 1'b0) $display("FAIL lb_be_we: got %h/%b want f/0", obs_be, obs_we); else n_pass++;
      n_checks++; if (obs_addr !== 32'h100) $display("FAIL lb_addr: got %h want 00000100", obs_addr); else n_pass++;
      run_access(1'b1, T_BU, 32'h101, 32'h0, 0, 1, 32'h000080FF, 1'b0);
      n_checks++; if (obs_rdm !== 32'h00000080) $display("FAIL lbu_data: got %h want 00000080", obs_rdm); else n_pass++;
      n_checks++; if (obs_stalls !== 2) $display("FAIL lbu_stalls: got %0d want 2", obs_stalls); else n_pass++;
   endtask

   task automatic test_lh_delay;
      run_access(1'b1, T_H, 32'h202, 32'h0, 0, 3, 32'h80011234, 1'b0);
      n_checks++; if (obs_stalls !== 4) $display("FAIL lh_stalls: got %0d want 4", obs_stalls); else n_pass++;
      n_checks++; if (obs_rdm !== 32'hFFFF8001) $display("FAIL lh_data: got %h want ffff8001", obs_rdm); else n_pass++;
   endtask

   task automatic test_reset_mid;
      MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = T_W; ALUResultM = 32'h100; dmem_req_ready = 1'b1;
      @(posedge clk); #1;
      dmem_req_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (StallM !== 1'b1) $display("FAIL rmid_resp_stall: got %b want 1", StallM); else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++; if (StallM !== 1'b0 || dmem_req_valid !== 1'b0) $display("FAIL rmid_async: got stall=%b valid=%b want 0/0", StallM, dmem_req_valid); else n_pass++;
      @(posedge clk); #1;
      MemReadM = 1'b0; reset = 1'b1;
      dmem_rsp_valid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      n_checks++; if (StallM !== 1'b0) $display("FAIL rmid_stall: got %b want 0", StallM); else n_pass++;
      n_checks++; if (ReadDataM !== 32'h0) $display("FAIL rmid_rdataq: got %h want 0", ReadDataM); else n_pass++;
      @(posedge clk); #1;
      dmem_rsp_valid = 1'b0;
      @(negedge clk);
      n_checks++; if (ReadDataM !== 32'h0 || StallM !== 1'b0) $display("FAIL rmid_ignored: got data=%h stall=%b want 0/0", ReadDataM, StallM); else n_pass++;
      @(posedge clk); #1;
      run_access(1'b1, T_W, 32'h104, 32'h0, 0, 1, 32'h12345678, 1'b0);
      n_checks++; if (obs_rdm !== 32'h12345678 || obs_stalls !== 2) $display("FAIL rmid_recover: got %h/%0d want 12345678/2", obs_rdm, obs_stalls); else n_pass++;
   endtask

   task automatic test_align;
`ifdef LSU_MISALIGN_TRAP_EN
      run_access(1'b1, T_W, 32'h101, 32'h0, 0, 1, 32'h11223344, 1'b0);
      n_checks++; if (obs_mis !== 1'b1) $display("FAIL mis_flag: got %b want 1", obs_mis); else n_pass++;
      n_checks++; if (obs_valids !== 0) $display("FAIL mis_valid: got %0d want 0", obs_valids); else n_pass++;
      n_checks++; if (obs_stalls !== 0) $display("FAIL mis_stall: got %0d want 0", obs_stalls); else n_pass++;
      n_checks++; if (obs_rdm !== 32'h0) $display("FAIL mis_rdata: got %h want 0", obs_rdm); else n_pass++;
`else
      run_access(1'b1, T_W, 32'h101, 32'h0, 0, 1, 32'h11223344, 1'b0);
      n_checks++; if (obs_mis !== 1'b0) $display("FAIL align_flag: got %b want 0", obs_mis); else n_pass++;
      n_checks++; if (obs_addr !== 32'h100) $display("FAIL align_addr: got %h want 00000100", obs_addr); else n_pass++;
      n_checks++; if (obs_be !== 4'hF) $display("FAIL align_be: got %h want f", obs_be); else n_pass++;
      n_checks++; if (obs_rdm !== 32'h11223344) $display("FAIL align_data: got %h want 11223344", obs_rdm); else n_pass++;
      run_access(1'b0, T_H, 32'h103, 32'h0000BEEF, 0, 1, 32'h0, 1'b0);
      n_checks++; if (obs_be !== 4'b1100) $display("FAIL align_sh_be: got %b want 1100", obs_be); else n_pass++;
`endif
   endtask

   task automatic test_random_back_to_back;
      logic [2:0]  ld_f3 [5] = '{T_B, T_H, T_W, T_BU, T_HU};
      logic        ld, mis;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rd;
      int          rdy, lat, exp_st;
      for (int n = 0; n < 60; n++) begin
         ld   = 1'($urandom_range(0, 1));
         f3   = ld ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         addr = $urandom; wd = $urandom; rd = $urandom;
         rdy  = $urandom_range(0, 2);
         lat  = $urandom_range(1, 3);
         mis  = m_mis(f3, addr);
         run_access(ld, f3, addr, wd, rdy, lat, rd, 1'b1);
         n_checks++; if (obs_timeout !== 1'b0) $display("FAIL rnd%0d_timeout", n); else n_pass++;
         n_checks++; if (obs_mis !== mis) $display("FAIL rnd%0d_mis: got %b want %b", n, obs_mis, mis); else n_pass++;
         if (mis) begin
            n_checks++; if (obs_valids !== 0 || obs_stalls !== 0) $display("FAIL rnd%0d_mis_quiet: got v=%0d s=%0d want 0/0", n, obs_valids, obs_stalls); else n_pass++;
            n_checks++; if (obs_rdm !== 32'h0) $display("FAIL rnd%0d_mis_rdata: got %h want 0", n, obs_rdm); else n_pass++;
         end else begin
            exp_st = ld ? rdy + 1 + lat : rdy;
            n_checks++; if (obs_valids !== rdy + 1) $display("FAIL rnd%0d_valid_cycles: got %0d want %0d", n, obs_valids, rdy + 1); else n_pass++;
            n_checks++; if (obs_stalls !== exp_st) $display("FAIL rnd%0d_stalls: got %0d want %0d", n, obs_stalls, exp_st); else n_pass++;
            n_checks++; if (obs_addr !== {addr[31:2], 2'b00}) $display("FAIL rnd%0d_addr: got %h want %h", n, obs_addr, {addr[31:2], 2'b00}); else n_pass++;
            n_checks++; if (obs_be !== m_be(ld, f3, addr)) $display("FAIL rnd%0d_be: got %h want %h", n, obs_be, m_be(ld, f3, addr)); else n_pass++;
            n_checks++; if (obs_we !== ~ld) $display("FAIL rnd%0d_we: got %b want %b", n, obs_we, ~ld); else n_pass++;
            n_checks++; if (obs_stable !== 1'b1) $display("FAIL rnd%0d_req_stable: got %b want 1", n, obs_stable); else n_pass++;
            if (ld) begin
               n_checks++; if (obs_rdm !== m_load(f3, addr, rd)) $display("FAIL rnd%0d_load f3=%b addr=%h: got %h want %h", n, f3, addr, obs_rdm, m_load(f3, addr, rd)); else n_pass++;
            end else begin
               n_checks++; if (obs_wdata !== m_wdata(f3, wd)) $display("FAIL rnd%0d_wdata: got %h want %h", n, obs_wdata, m_wdata(f3, wd)); else n_pass++;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw();
      test_sb_wait();
      test_lb();
      test_lh_delay();
      test_reset_mid();
      test_align();
      test_random_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
